// File: rtl/qudou_pkg.sv
// qudou_pkg: shared timing defaults (10 ms clock) and counter width helper
package qudou_pkg;
  localparam int DEF_STABLE = 4;
  localparam int DEF_LONG = 100;
  localparam int DEF_REPEAT = 20;
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/qudou_ch.sv
// qudou_ch: one key channel with synchroniser, debounce, press/release, long-press and auto-repeat
module qudou_ch
  import qudou_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE,
  parameter int LONG_CYCLES = DEF_LONG,
  parameter int REPEAT_CYCLES = DEF_REPEAT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic k,
  output logic keyout,
  output logic press_p,
  output logic release_p,
  output logic long_p,
  output logic repeat_p,
  output logic held_long
);
  localparam int DW = cnt_w(STABLE_CYCLES + 1);
  localparam int HW = cnt_w(LONG_CYCLES + 1);
  logic s1, s;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  logic flip, rel, long_hit;
  // accept a level change after STABLE_CYCLES disagreeing samples; release blocks any hold pulse
  always_comb begin
    flip = (s != keyout) && (dcnt == DW'(STABLE_CYCLES - 1));
    rel = flip && keyout;
    long_hit = keyout && !rel && (hcnt == HW'(LONG_CYCLES - 1));
  end
  // synchroniser, debounce counter, debounced level and edge pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s <= 1'b0;
      dcnt <= '0;
      keyout <= 1'b0;
      press_p <= 1'b0;
      release_p <= 1'b0;
    end else begin
      s1 <= k;
      s <= s1;
      dcnt <= (s == keyout || flip) ? '0 : dcnt + 1'b1;
      keyout <= flip ? s : keyout;
      press_p <= flip && s;
      release_p <= rel;
    end
  end
  // saturating hold counter and long-press level/pulse, all cleared on release
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hcnt <= '0;
      long_p <= 1'b0;
      held_long <= 1'b0;
    end else begin
      hcnt <= (!keyout || rel) ? '0 : (hcnt == HW'(LONG_CYCLES)) ? hcnt : hcnt + 1'b1;
      long_p <= long_hit;
      held_long <= !rel && (held_long || long_hit);
    end
  end
  if (REPEAT_CYCLES > 0) begin : g_rep
    localparam int RW = cnt_w(REPEAT_CYCLES);
    logic [RW-1:0] rcnt;
    logic wrap;
    assign wrap = rcnt == RW'(REPEAT_CYCLES - 1);
    // wrapping repeat counter that only runs while the long hold is active
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        rcnt <= '0;
        repeat_p <= 1'b0;
      end else begin
        rcnt <= (!held_long || rel || wrap) ? '0 : rcnt + 1'b1;
        repeat_p <= held_long && !rel && wrap;
      end
    end
  end else begin : g_norep
    assign repeat_p = 1'b0;
  end
endmodule

// File: rtl/qudou_multi.sv
// qudou_multi: bank of independent debounced key channels with polarity normalisation
module qudou_multi
  import qudou_pkg::*;
#(
  parameter int N_KEYS = 4,
  parameter int STABLE_CYCLES = DEF_STABLE,
  parameter int LONG_CYCLES = DEF_LONG,
  parameter int REPEAT_CYCLES = DEF_REPEAT,
  parameter int ACTIVE_HIGH = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] keyin,
  output logic [N_KEYS-1:0] keyout,
  output logic [N_KEYS-1:0] press_p,
  output logic [N_KEYS-1:0] release_p,
  output logic [N_KEYS-1:0] long_p,
  output logic [N_KEYS-1:0] repeat_p,
  output logic [N_KEYS-1:0] held_long
);
  logic [N_KEYS-1:0] k;
  assign k = (ACTIVE_HIGH != 0) ? keyin : ~keyin;
  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    qudou_ch #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .LONG_CYCLES(LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clock(clock),
      .reset_n(reset_n),
      .k(k[i]),
      .keyout(keyout[i]),
      .press_p(press_p[i]),
      .release_p(release_p[i]),
      .long_p(long_p[i]),
      .repeat_p(repeat_p[i]),
      .held_long(held_long[i])
    );
  end
endmodule

// File: tb/tb_qudou_multi.sv
// tb_qudou_multi: directed checks of debounce timing, pulses, long-press, repeat, polarity and reset
module tb_qudou_multi;
  logic clock = 1'b0;
  logic reset_n;
  logic [3:0] keyin, keyout, press_p, release_p, long_p, repeat_p, held_long;
  logic [3:0] keyin_n, keyout_n, press_p_n, release_p_n, long_p_n, repeat_p_n, held_long_n;
  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  qudou_multi dut (
    .clock(clock), .reset_n(reset_n), .keyin(keyin), .keyout(keyout), .press_p(press_p),
    .release_p(release_p), .long_p(long_p), .repeat_p(repeat_p), .held_long(held_long)
  );

  qudou_multi #(.ACTIVE_HIGH(0), .REPEAT_CYCLES(0)) dut_n (
    .clock(clock), .reset_n(reset_n), .keyin(keyin_n), .keyout(keyout_n), .press_p(press_p_n),
    .release_p(release_p_n), .long_p(long_p_n), .repeat_p(repeat_p_n), .held_long(held_long_n)
  );

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    keyin = '0;
    keyin_n = '1;
    repeat (3) step;
    vectors++;
    if ({keyout, press_p, release_p, long_p, repeat_p, held_long} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", {keyout, press_p, release_p, long_p, repeat_p, held_long});
    end
    vectors++;
    if ({keyout_n, press_p_n, release_p_n, long_p_n, repeat_p_n, held_long_n} !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_outputs_n: got %h want 0", {keyout_n, press_p_n, release_p_n, long_p_n, repeat_p_n, held_long_n});
    end
    reset_n = 1'b1;
    repeat (10) step;
    vectors++;
    if ({keyout, press_p, release_p, long_p, repeat_p, held_long} !== 24'h0) begin
      miscompares++;
      $display("FAIL idle_outputs: got %h want 0", {keyout, press_p, release_p, long_p, repeat_p, held_long});
    end
    vectors++;
    if ({keyout_n, press_p_n, release_p_n, long_p_n, repeat_p_n, held_long_n} !== 24'h0) begin
      miscompares++;
      $display("FAIL idle_outputs_n: got %h want 0", {keyout_n, press_p_n, release_p_n, long_p_n, repeat_p_n, held_long_n});
    end
  endtask

  task automatic test_clean_press;
    int pa = -1, pc = 0, ra = -1, rc = 0, kc = 0, lc = 0;
    keyin[0] = 1'b1;
    for (int t = 1; t <= 80; t++) begin
      step;
      if (press_p[0]) begin pc++; if (pa < 0) pa = t; end
      if (release_p[0]) begin rc++; if (ra < 0) ra = t; end
      if (keyout[0]) kc++;
      if (long_p[0]) lc++;
      if (t == 60) keyin[0] = 1'b0;
    end
    vectors++;
    if (pa !== 6) begin miscompares++; $display("FAIL clean_press_at: got %0d want 6", pa); end
    vectors++;
    if (pc !== 1) begin miscompares++; $display("FAIL clean_press_count: got %0d want 1", pc); end
    vectors++;
    if (kc !== 60) begin miscompares++; $display("FAIL clean_keyout_len: got %0d want 60", kc); end
    vectors++;
    if (ra !== 66) begin miscompares++; $display("FAIL clean_release_at: got %0d want 66", ra); end
    vectors++;
    if (rc !== 1) begin miscompares++; $display("FAIL clean_release_count: got %0d want 1", rc); end
    vectors++;
    if (lc !== 0) begin miscompares++; $display("FAIL clean_no_long: got %0d want 0", lc); end
  endtask

  task automatic test_bounce(input int hi, input int want_at);
    int pa = -1, pc = 0, rc = 0;
    int per;
    per = hi + 1;
    keyin[1] = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      step;
      if (press_p[1]) begin pc++; if (pa < 0) pa = t; end
      if (release_p[1]) rc++;
      keyin[1] = (t + 1 > 5 * per) ? 1'b1 : (((t) % per) < hi);
    end
    vectors++;
    if (pa !== want_at) begin miscompares++; $display("FAIL bounce%0d_press_at: got %0d want %0d", hi, pa, want_at); end
    vectors++;
    if (pc !== 1 || rc !== 0) begin
      miscompares++;
      $display("FAIL bounce%0d_pulses: got press %0d release %0d want 1 0", hi, pc, rc);
    end
    keyin[1] = 1'b0;
    repeat (12) step;
  endtask

  task automatic test_long_repeat;
    int pa = -1, la = -1, lc = 0, ha = -1, hc = 0, rc = 0, rbad = 0, ra = -1, hrel = -1, h210 = -1;
    keyin[2] = 1'b1;
    for (int t = 1; t <= 240; t++) begin
      step;
      if (press_p[2] && pa < 0) pa = t;
      if (long_p[2]) begin lc++; if (la < 0) la = t; end
      if (held_long[2]) begin hc++; if (ha < 0) ha = t; end
      if (repeat_p[2]) begin if (t != 126 + 20 * rc) rbad++; rc++; end
      if (release_p[2] && ra < 0) begin ra = t; hrel = int'(held_long[2]); end
      if (t == 210) h210 = int'(held_long[2]);
      if (t == 205) keyin[2] = 1'b0;
    end
    vectors++;
    if (pa !== 6) begin miscompares++; $display("FAIL long_press_at: got %0d want 6", pa); end
    vectors++;
    if (la !== 106 || lc !== 1) begin miscompares++; $display("FAIL long_pulse: got at %0d count %0d want 106 1", la, lc); end
    vectors++;
    if (ha !== 106 || hc !== 105) begin miscompares++; $display("FAIL held_long: got from %0d len %0d want 106 105", ha, hc); end
    vectors++;
    if (rc !== 5 || rbad !== 0) begin miscompares++; $display("FAIL repeat_pulses: got count %0d misplaced %0d want 5 0", rc, rbad); end
    vectors++;
    if (ra !== 211) begin miscompares++; $display("FAIL long_release_at: got %0d want 211", ra); end
    vectors++;
    if (hrel !== 0 || h210 !== 1) begin miscompares++; $display("FAIL held_drop: got rel %0d before %0d want 0 1", hrel, h210); end
  endtask

  task automatic test_release_race;
    int la = -1, rc = 0, ra = -1, hrel = -1;
    keyin[2] = 1'b1;
    for (int t = 1; t <= 150; t++) begin
      step;
      if (long_p[2] && la < 0) la = t;
      if (repeat_p[2]) rc++;
      if (release_p[2] && ra < 0) begin ra = t; hrel = int'(held_long[2]); end
      if (t == 120) keyin[2] = 1'b0;
    end
    vectors++;
    if (la !== 106) begin miscompares++; $display("FAIL race_long_at: got %0d want 106", la); end
    vectors++;
    if (ra !== 126 || hrel !== 0) begin miscompares++; $display("FAIL race_release: got at %0d held %0d want 126 0", ra, hrel); end
    vectors++;
    if (rc !== 0) begin miscompares++; $display("FAIL race_repeat_suppressed: got %0d want 0", rc); end
  endtask

  task automatic test_polarity;
    int pa = -1, kc = 0, la = -1, lc = 0, rc = 0, ra = -1;
    keyin_n[0] = 1'b0;
    for (int t = 1; t <= 180; t++) begin
      step;
      if (press_p_n[0] && pa < 0) pa = t;
      if (keyout_n[0]) kc++;
      if (long_p_n[0]) begin lc++; if (la < 0) la = t; end
      if (repeat_p_n !== 4'b0) rc++;
      if (release_p_n[0] && ra < 0) ra = t;
      if (t == 150) keyin_n[0] = 1'b1;
    end
    vectors++;
    if (pa !== 6 || kc !== 150) begin miscompares++; $display("FAIL pol_press: got at %0d len %0d want 6 150", pa, kc); end
    vectors++;
    if (la !== 106 || lc !== 1) begin miscompares++; $display("FAIL pol_long: got at %0d count %0d want 106 1", la, lc); end
    vectors++;
    if (rc !== 0) begin miscompares++; $display("FAIL pol_no_repeat: got %0d want 0", rc); end
    vectors++;
    if (ra !== 156) begin miscompares++; $display("FAIL pol_release_at: got %0d want 156", ra); end
  endtask

  task automatic test_reset_mid_hold;
    int pa = -1, k56 = -1, nz = 0, pa2 = -1, la2 = -1;
    keyin[3] = 1'b1;
    for (int t = 1; t <= 56; t++) begin
      step;
      if (press_p[3] && pa < 0) pa = t;
      if (t == 56) k56 = int'(keyout[3]);
    end
    vectors++;
    if (pa !== 6 || k56 !== 1) begin miscompares++; $display("FAIL rmh_first_press: got at %0d keyout %0d want 6 1", pa, k56); end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({keyout, press_p, release_p, long_p, repeat_p, held_long} !== 24'h0) begin
      miscompares++;
      $display("FAIL rmh_async_clear: got %h want 0", {keyout, press_p, release_p, long_p, repeat_p, held_long});
    end
    for (int t = 1; t <= 3; t++) begin
      step;
      if ({keyout, press_p, release_p, long_p, repeat_p, held_long} !== 24'h0) nz++;
    end
    vectors++;
    if (nz !== 0) begin miscompares++; $display("FAIL rmh_quiet_in_reset: got %0d nonzero cycles want 0", nz); end
    reset_n = 1'b1;
    for (int t = 1; t <= 120; t++) begin
      step;
      if (press_p[3] && pa2 < 0) pa2 = t;
      if (long_p[3] && la2 < 0) la2 = t;
    end
    vectors++;
    if (pa2 !== 6) begin miscompares++; $display("FAIL rmh_repress_at: got %0d want 6", pa2); end
    vectors++;
    if (la2 !== 106) begin miscompares++; $display("FAIL rmh_hold_restart: got %0d want 106", la2); end
    keyin[3] = 1'b0;
    repeat (12) step;
  endtask

  task automatic test_independent;
    logic [3:0] pv = '0, rv = '0;
    int pcyc = 0, rcyc = 0;
    keyin = 4'b1001;
    for (int t = 1; t <= 40; t++) begin
      step;
      if (press_p !== 4'b0) pcyc++;
      if (release_p !== 4'b0) rcyc++;
      if (t == 6) pv = press_p;
      if (t == 26) rv = release_p;
      if (t == 20) keyin = 4'b0;
    end
    vectors++;
    if (pv !== 4'b1001 || pcyc !== 1) begin miscompares++; $display("FAIL indep_press: got %b in %0d cycles want 1001 1", pv, pcyc); end
    vectors++;
    if (rv !== 4'b1001 || rcyc !== 1) begin miscompares++; $display("FAIL indep_release: got %b in %0d cycles want 1001 1", rv, rcyc); end
  endtask

  initial begin
    test_reset;
    test_clean_press;
    repeat (10) step;
    test_bounce(1, 16);
    test_bounce(3, 26);
    test_long_repeat;
    repeat (10) step;
    test_release_race;
    repeat (10) step;
    test_polarity;
    repeat (10) step;
    test_reset_mid_hold;
    test_independent;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
